// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, FSM encoding and baud divisor lookup.
package uart_pkg;

    // Frame format
    localparam int   DATA_BITS       = 8;
    localparam logic PARITY_EVEN     = 1'b1;
    localparam logic START_LVL       = 1'b0;
    localparam logic STOP_LVL        = 1'b1;

    // Sample ticks per bit period used to derive the divisors
    localparam int   SAMPLES_PER_BIT = 16;

    // Wide enough for the slowest rate (10417 at 50 MHz / 300 baud)
    localparam int   DIV_W           = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Line rate selected by baud_select
    function automatic int baud_rate(input int sel);
        case (sel)
            0:       return 300;
            1:       return 1200;
            2:       return 4800;
            3:       return 9600;
            4:       return 19200;
            5:       return 38400;
            6:       return 57600;
            default: return 115200;
        endcase
    endfunction

    // Sample-tick divisor, rounded to nearest: round(clk_freq / (16 * baud))
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq, input int sel);
        int rate;
        rate = baud_rate(sel);
        return DIV_W'((clk_freq + (SAMPLES_PER_BIT / 2) * rate) / (SAMPLES_PER_BIT * rate));
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Free-running sample-tick generator: one-cycle pulse every DIV clocks.
module baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    // Divisors are resolved at elaboration; only the table lookup is hardware
    localparam logic [DIV_W-1:0] DIV_TABLE [8] = '{
        baud_div(CLK_FREQ, 0), baud_div(CLK_FREQ, 1),
        baud_div(CLK_FREQ, 2), baud_div(CLK_FREQ, 3),
        baud_div(CLK_FREQ, 4), baud_div(CLK_FREQ, 5),
        baud_div(CLK_FREQ, 6), baud_div(CLK_FREQ, 7)
    };

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] tick_cnt;

    assign div = DIV_TABLE[baud_select];

    // Count to DIV-1 and emit a tick; '>=' recovers if a rate change shrinks DIV
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt      <= '0;
            sample_ENABLE <= 1'b0;
        end else if (tick_cnt >= div - DIV_W'(1)) begin
            tick_cnt      <= '0;
            sample_ENABLE <= 1'b1;
        end else begin
            tick_cnt      <= tick_cnt + DIV_W'(1);
            sample_ENABLE <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver: start, 8 data LSB first, even parity, stop.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam int                SCNT_W   = $clog2(OVERSAMPLE);
    localparam logic [SCNT_W-1:0] MID      = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam int                IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]  LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 sample_tick;
    logic                 rxd_p0;
    logic                 rxd_p1;
    logic                 rxd_p2;
    logic                 fall_edge;
    logic                 mid_bit;
    rx_state_t            state;
    logic [SCNT_W-1:0]    sample_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;

    baud_controller #(
        .CLK_FREQ      (CLK_FREQ)
    ) u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_tick)
    );

    // Two-flop synchronizer (p0, p1) plus one delay flop (p2) for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
            rxd_p2 <= 1'b1;
        end else begin
            rxd_p0 <= RxD;
            rxd_p1 <= rxd_p0;
            rxd_p2 <= rxd_p1;
        end
    end

    assign fall_edge = rxd_p2 & ~rxd_p1;
    assign mid_bit   = sample_tick && (sample_cnt == MID);

    // Frame FSM with registered outputs; the sample counter wraps every 16 ticks,
    // so after the start-bit midpoint each later midpoint falls exactly one bit on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            Rx_DATA    <= '0;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (sample_tick) begin
                sample_cnt <= sample_cnt + SCNT_W'(1);
            end
            if (!Rx_EN) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall_edge) begin
                            sample_cnt <= '0;
                            bit_idx    <= '0;
                            state      <= START;
                        end
                    end
                    START: begin
                        if (mid_bit) begin
                            if (rxd_p1 != START_LVL) begin
                                state <= IDLE;
                            end else begin
                                Rx_PERROR <= 1'b0;
                                Rx_FERROR <= 1'b0;
                                state     <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (mid_bit) begin
                            shift   <= {rxd_p1, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (bit_idx == LAST_BIT) begin
                                state <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (mid_bit) begin
                            perr  <= (^{rxd_p1, shift}) ^ ~PARITY_EVEN;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (mid_bit) begin
                            if (!perr && (rxd_p1 == STOP_LVL)) begin
                                Rx_DATA  <= shift;
                                Rx_VALID <= 1'b1;
                            end else begin
                                Rx_PERROR <= perr;
                                Rx_FERROR <= (rxd_p1 != STOP_LVL);
                            end
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
